multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/upower_pkg.sv | 44 ++++
 rtl/opcode_classifier.sv | 23 ++
 rtl/multicycle_sequencer.sv | 154 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/upower_pkg.sv
// Shared encodings for the multicycle sequencer: FSM states, opcode classes
// and the primary opcode values recognised by the classifier.
package upower_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_BRANCH = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    // CLS_NONE is the post-reset value before any instruction has been decoded
    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_XALU    = 3'd1,
        CLS_DALU    = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_B       = 3'd5,
        CLS_BC      = 3'd6,
        CLS_ILLEGAL = 3'd7
    } op_class_e;

    localparam logic [5:0] OP_XALU    = 6'd31;
    localparam logic [5:0] OP_DALU_A  = 6'd14;
    localparam logic [5:0] OP_DALU_B  = 6'd15;
    localparam logic [5:0] OP_DALU_C  = 6'd24;
    localparam logic [5:0] OP_DALU_D  = 6'd26;
    localparam logic [5:0] OP_DALU_E  = 6'd28;
    localparam logic [5:0] OP_LOAD_A  = 6'd32;
    localparam logic [5:0] OP_LOAD_B  = 6'd34;
    localparam logic [5:0] OP_LOAD_C  = 6'd40;
    localparam logic [5:0] OP_LOAD_D  = 6'd42;
    localparam logic [5:0] OP_LOAD_E  = 6'd58;
    localparam logic [5:0] OP_STORE_A = 6'd36;
    localparam logic [5:0] OP_STORE_B = 6'd37;
    localparam logic [5:0] OP_STORE_C = 6'd38;
    localparam logic [5:0] OP_STORE_D = 6'd44;
    localparam logic [5:0] OP_STORE_E = 6'd62;
    localparam logic [5:0] OP_B       = 6'd18;
    localparam logic [5:0] OP_BC      = 6'd19;

endpackage

// File: rtl/opcode_classifier.sv
// Purely combinational map from a 6-bit primary opcode to its instruction class.
module opcode_classifier
    import upower_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_e  op_class
);

    // Anything not listed is illegal and sends the sequencer to HALT
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_XALU:                                                  op_class = CLS_XALU;
            OP_DALU_A, OP_DALU_B, OP_DALU_C, OP_DALU_D, OP_DALU_E:    op_class = CLS_DALU;
            OP_LOAD_A, OP_LOAD_B, OP_LOAD_C, OP_LOAD_D, OP_LOAD_E:    op_class = CLS_LOAD;
            OP_STORE_A, OP_STORE_B, OP_STORE_C, OP_STORE_D, OP_STORE_E: op_class = CLS_STORE;
            OP_B:                                                     op_class = CLS_B;
            OP_BC:                                                    op_class = CLS_BC;
            default:                                                  op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/BRANCH/HALT control
// FSM with a sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_sequencer
    import upower_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic        pc_src,
    output logic        trap,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    op_class_e   class_r;
    op_class_e   cls_s;
    logic        trap_r;
    logic [31:0] retired_r;

    logic imem_req_s, ir_load_s, dmem_req_s, mem_read_s, mem_write_s;
    logic alu_src_s, reg_write_s, mem_to_reg_s, pc_write_s, pc_src_s;

    opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (cls_s)
    );

    // Next-state and output decode; ready-qualified strobes are suppressed under reset
    always_comb begin
        next_state_s = state_r;
        imem_req_s   = 1'b0;
        ir_load_s    = 1'b0;
        dmem_req_s   = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        alu_src_s    = 1'b0;
        reg_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_load_s    = ~rst;
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (cls_s)
                    CLS_XALU, CLS_DALU, CLS_LOAD, CLS_STORE: next_state_s = ST_EXEC;
                    CLS_B, CLS_BC:                           next_state_s = ST_BRANCH;
                    default:                                 next_state_s = ST_HALT;
                endcase
            end
            ST_EXEC: begin
                alu_src_s = (class_r == CLS_DALU) || (class_r == CLS_LOAD) ||
                            (class_r == CLS_STORE);
                if ((class_r == CLS_LOAD) || (class_r == CLS_STORE)) begin
                    next_state_s = ST_MEM;
                end else if ((class_r == CLS_XALU) || (class_r == CLS_DALU)) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            ST_MEM: begin
                dmem_req_s  = 1'b1;
                alu_src_s   = 1'b1;
                mem_read_s  = (class_r == CLS_LOAD);
                mem_write_s = (class_r == CLS_STORE);
                if (!dmem_ready) begin
                    next_state_s = ST_MEM;
                end else if (class_r == CLS_LOAD) begin
                    next_state_s = ST_WB;
                end else if (class_r == CLS_STORE) begin
                    pc_write_s   = ~rst;
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = (class_r == CLS_LOAD);
                pc_write_s   = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_BRANCH: begin
                pc_write_s   = 1'b1;
                pc_src_s     = (class_r == CLS_B) ? 1'b1 : branch_taken;
                next_state_s = ST_FETCH;
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_FETCH;
            end
        endcase
    end

    // State, registered class, sticky trap and retired counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            class_r   <= CLS_NONE;
            trap_r    <= 1'b0;
            retired_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_DECODE) begin
                class_r <= cls_s;
            end
            if (next_state_s == ST_HALT) begin
                trap_r <= 1'b1;
            end
            if (pc_write_s) begin
                retired_r <= retired_r + 32'd1;
            end
        end
    end

    assign imem_req   = imem_req_s;
    assign ir_load    = ir_load_s;
    assign dmem_req   = dmem_req_s;
    assign mem_read   = mem_read_s;
    assign mem_write  = mem_write_s;
    assign alu_src    = alu_src_s;
    assign reg_write  = reg_write_s;
    assign mem_to_reg = mem_to_reg_s;
    assign pc_write   = pc_write_s;
    assign pc_src     = pc_src_s;
    assign trap       = trap_r;
    assign state      = state_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: per-cycle expected outputs are queued
// with the stimulus, then replayed and checked one cycle at a time.
module tb_multicycle_sequencer;
    import upower_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
    logic        imem_req, ir_load, dmem_req, mem_read, mem_write, alu_src;
    logic        reg_write, mem_to_reg, pc_write, pc_src, trap;
    logic [2:0]  state;
    logic [31:0] retired;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req),
        .ir_load(ir_load), .dmem_req(dmem_req), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src),
        .trap(trap), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Output bit masks in the order {imem_req, ir_load, dmem_req, mem_read, mem_write,
    // alu_src, reg_write, mem_to_reg, pc_write, pc_src, trap}
    localparam logic [10:0] O_NONE = 11'd0;
    localparam logic [10:0] O_IMRQ = 11'b100_0000_0000;
    localparam logic [10:0] O_IRLD = 11'b010_0000_0000;
    localparam logic [10:0] O_DMRQ = 11'b001_0000_0000;
    localparam logic [10:0] O_MRD  = 11'b000_1000_0000;
    localparam logic [10:0] O_MWR  = 11'b000_0100_0000;
    localparam logic [10:0] O_ALUS = 11'b000_0010_0000;
    localparam logic [10:0] O_REGW = 11'b000_0001_0000;
    localparam logic [10:0] O_M2R  = 11'b000_0000_1000;
    localparam logic [10:0] O_PCW  = 11'b000_0000_0100;
    localparam logic [10:0] O_PCS  = 11'b000_0000_0010;
    localparam logic [10:0] O_TRAP = 11'b000_0000_0001;

    typedef struct packed {
        logic        r;
        logic        ir;
        logic        dr;
        logic        bt;
        logic        ld;
        logic [5:0]  op;
        logic [2:0]  st;
        logic [10:0] o;
        logic [31:0] ret;
    } step_t;

    step_t       sb[$];
    logic [31:0] exp_ret = 32'd0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    // 0 XALU, 1 DALU, 2 LOAD, 3 STORE, 4 B, 5 BC, 6 illegal
    function automatic int klass(input logic [5:0] op);
        case (op)
            6'd31:                             return 0;
            6'd14, 6'd15, 6'd24, 6'd26, 6'd28: return 1;
            6'd32, 6'd34, 6'd40, 6'd42, 6'd58: return 2;
            6'd36, 6'd37, 6'd38, 6'd44, 6'd62: return 3;
            6'd18:                             return 4;
            6'd19:                             return 5;
            default:                           return 6;
        endcase
    endfunction

    task automatic push(input logic r, input logic ir, input logic dr, input logic bt,
                        input logic [5:0] op, input logic [2:0] st, input logic [10:0] o);
        step_t s;
        s = '{r: r, ir: ir, dr: dr, bt: bt, ld: 1'b0, op: op, st: st, o: o, ret: exp_ret};
        sb.push_back(s);
        if (r) exp_ret = 32'd0;
        else if (o[2]) exp_ret = exp_ret + 32'd1;
    endtask

    // One instruction from FETCH; abort asserts rst after dw MEM wait cycles
    task automatic instr(input logic [5:0] op, input int iw, input int dw,
                         input logic bt, input logic abort);
        int k;
        logic [10:0] mo;
        k = klass(op);
        for (int i = 0; i < iw; i++) push(1'b0, 1'b0, rb(), rb(), op, ST_FETCH, O_IMRQ);
        push(1'b0, 1'b1, rb(), rb(), op, ST_FETCH, O_IMRQ | O_IRLD);
        push(1'b0, rb(), rb(), rb(), op, ST_DECODE, O_NONE);
        case (k)
            0, 1: begin
                push(1'b0, rb(), rb(), rb(), rop(), ST_EXEC, (k == 1) ? O_ALUS : O_NONE);
                push(1'b0, rb(), rb(), rb(), rop(), ST_WB, O_REGW | O_PCW);
            end
            2, 3: begin
                mo = O_DMRQ | O_ALUS | ((k == 2) ? O_MRD : O_MWR);
                push(1'b0, rb(), rb(), rb(), rop(), ST_EXEC, O_ALUS);
                for (int i = 0; i < dw; i++) push(1'b0, rb(), 1'b0, rb(), rop(), ST_MEM, mo);
                if (abort) begin
                    push(1'b1, 1'b0, 1'b1, rb(), rop(), ST_MEM, mo);
                end else if (k == 2) begin
                    push(1'b0, rb(), 1'b1, rb(), rop(), ST_MEM, mo);
                    push(1'b0, rb(), rb(), rb(), rop(), ST_WB, O_REGW | O_M2R | O_PCW);
                end else begin
                    push(1'b0, rb(), 1'b1, rb(), rop(), ST_MEM, mo | O_PCW);
                end
            end
            4: push(1'b0, rb(), rb(), rb(), rop(), ST_BRANCH, O_PCW | O_PCS);
            5: push(1'b0, rb(), rb(), bt, rop(), ST_BRANCH, bt ? (O_PCW | O_PCS) : O_PCW);
            default: begin
                for (int i = 0; i < 4; i++)
                    push(1'b0, 1'(i % 2 == 0), rb(), rb(), rop(), ST_HALT, O_TRAP);
            end
        endcase
    endtask

    task automatic drain();
        step_t s;
        logic [13:0] act;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            rst = s.r; imem_ready = s.ir; dmem_ready = s.dr;
            branch_taken = s.bt; opcode = s.op;
            if (s.ld) begin
                force dut.retired_r = s.ret;
                release dut.retired_r;
            end
            #1;
            act = {state, imem_req, ir_load, dmem_req, mem_read, mem_write, alu_src,
                   reg_write, mem_to_reg, pc_write, pc_src, trap};
            tests++;
            assert (act === {s.st, s.o}) else begin
                fails++;
                $error("FAIL cyc%0d outputs: got st=%0d o=%b, expected st=%0d o=%b",
                       cyc, act[13:11], act[10:0], s.st, s.o);
            end
            tests++;
            assert (retired === s.ret) else begin
                fails++;
                $error("FAIL cyc%0d retired: got %h, expected %h", cyc, retired, s.ret);
            end
            cyc++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        // reset held with imem_ready high: FETCH, imem_req only
        push(1'b1, 1'b1, 1'b1, 1'b0, 6'd31, ST_FETCH, O_IMRQ);
        instr(6'd31, 0, 0, 1'b0, 1'b0);
        instr(6'd14, 1, 0, 1'b0, 1'b0);
        instr(6'd26, 0, 0, 1'b0, 1'b0);
        instr(6'd32, 0, 3, 1'b0, 1'b0);
        instr(6'd40, 2, 0, 1'b0, 1'b0);
        instr(6'd36, 1, 1, 1'b0, 1'b0);
        instr(6'd62, 0, 0, 1'b0, 1'b0);
        instr(6'd19, 0, 0, 1'b0, 1'b0);
        instr(6'd19, 0, 0, 1'b1, 1'b0);
        instr(6'd18, 0, 0, 1'b0, 1'b0);
        instr(6'd0,  0, 0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, ST_HALT, O_TRAP);
        push(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, ST_FETCH, O_IMRQ);
        instr(6'd24, 0, 0, 1'b0, 1'b0);
        instr(6'd36, 0, 2, 1'b0, 1'b1);
        instr(6'd31, 0, 0, 1'b0, 1'b0);
        drain();
        // counter wrap: preload to 0xFFFFFFFE, then two stores
        exp_ret = 32'hFFFF_FFFE;
        instr(6'd44, 0, 0, 1'b0, 1'b0);
        sb[0].ld = 1'b1;
        instr(6'd37, 0, 1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, ST_FETCH, O_IMRQ);
        drain();
        tests++;
        assert (retired === 32'd0) else begin
            fails++;
            $error("FAIL wrap: got %h, expected 0", retired);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
